pipe_nreg: RTL and testbench
============================

# pipe_nreg

Parametrised pipeline register chain: a WIDTH-bit, DEPTH-stage generalisation of the load-enabled N-bit register. Each stage carries a valid bit, and stages move data with a valid/ready handshake. Empty stages collapse (bubbles are squeezed out), so a stalled consumer back-pressures the producer only when every stage is full. It is used between CPU pipeline stages and for fixed-latency operand delay, with stall and flush.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 2, number of register stages (≥1)
- CW, $clog2(DEPTH+1), width of occupancy count (derived; not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high; clears all state immediately
- in_valid  input  1  producer has data on `in`
- in_ready  output  1  chain accepts `in` this cycle
- in  input  WIDTH  input data
- out_valid  output  1  last stage holds valid data
- out_ready  input  1  consumer takes `out` this cycle
- out  output  WIDTH  data of last stage
- flush  input  1  synchronous discard of all contents (see Configuration)
- count  output  CW  number of valid stages, 0..DEPTH

## Operation
- State: stages s[0..DEPTH-1], each with v[i] (valid) and d[i] (WIDTH data). s[0] is the entry stage; s[DEPTH-1] drives `out`/`out_valid`.
- Advance rules, evaluated combinationally each cycle:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - For i<DEPTH-1: adv[i] = v[i] & (!v[i+1] | adv[i+1]).
  - in_ready = !v[0] | adv[0].
- At each rising edge:
  - A stage i>0 loads d[i-1] and sets v[i] when adv[i-1].
  - Otherwise v[i] clears if adv[i]; else it holds.
  - s[0] loads `in` and sets v[0] on in_valid & in_ready. Otherwise v[0] clears if adv[0]; else it holds.
- Data in a non-advancing valid stage holds unchanged. Data in invalid stages is don't-care, but must not change while the stage is valid.
- Order is strictly FIFO. No item is duplicated or dropped, except on flush or reset.
- count = popcount(v). It is registered alongside v and consistent with v every cycle.
- in_valid while in_ready=0: the input is not taken. The producer must hold `in` stable.
- Full (count=DEPTH) with out_ready=1: in_ready=1. Simultaneous enqueue and dequeue keeps count at DEPTH.
- Empty: out_valid=0, `out` holds the last value it had.

## Timing
- Reset values: all v=0, all d=0. So out_valid=0, out=0, count=0. in_ready=1 while rst is low with an empty chain.
- rst asserted mid-operation clears everything asynchronously. No data survives, and the first edge after release behaves as if from empty.
- Latency through an empty chain with out_ready=1: an item accepted at edge k is presented with out_valid=1 after edge k+DEPTH-1. That is DEPTH cycles from in_valid high to out_valid high.
- Throughput is 1 item per cycle when out_ready stays high.
- in_ready has a combinational path from out_ready through the chain. There is no combinational path from in_valid to out_valid.

## Configuration
- Macro `PIPE_NREG_FLUSH_EN`.
- Defined:
  - flush=1 at an edge clears all v and sets count to 0.
  - While flush=1, in_ready=0, out_valid=0 and no transfer occurs on either side.
  - Flush takes priority over enqueue and dequeue in the same cycle.
  - d[] is unchanged by flush.
- Undefined: the flush port is present but ignored. There is no flush logic, and in_ready/out_valid follow only the advance rules.

## Test plan
- Reset: drive in_valid=1, in=0xA5, rst=1 mid-cycle. Expect out_valid=0, out=0x00 and count=0 immediately, and the chain empty after release.
- Streaming: WIDTH=8, DEPTH=3, out_ready=1, inputs 0x01..0x05 on consecutive cycles. Expect out_valid to rise 3 cycles after the first in_valid, output 0x01..0x05 back to back, and count to peak at 3.
- Back-pressure: out_ready=0 while 4 items are offered to DEPTH=3. Expect in_ready=0 after 3 accepts and count=3. Then raise out_ready. Expect the 4th item accepted in the same cycle the first leaves, with count staying at 3.
- Bubble collapse: DEPTH=4, enqueue 0x11, idle one cycle, enqueue 0x22, out_ready=0. Expect both items in s[3] and s[2] and count=2. Release: expect 0x11 then 0x22 on consecutive cycles.
- Flush (`PIPE_NREG_FLUSH_EN` defined): with count=2, assert flush together with in_valid=1, in=0x33. Expect count=0 and out_valid=0 next cycle, and 0x33 not captured.
- Flush ignored (macro undefined): same stimulus. Expect 0x33 accepted and count=3, and original order preserved at the output.

Source files
------------

// File: rtl/pipe_nreg.sv
// rtl/pipe_nreg.sv - valid/ready pipeline register chain with bubble collapse
// Defining PIPE_NREG_FLUSH_EN enables the synchronous flush input.
module pipe_nreg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             hold;
  logic             take;

`ifdef PIPE_NREG_FLUSH_EN
  assign hold = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign hold         = 1'b0;
`endif

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] b);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + CW'(b[i]);
    end
    return c;
  endfunction

  // Advance ripples from the output back toward the entry, so a full chain
  // can still accept when the consumer drains in the same cycle.
  always_comb begin
    logic chain_adv;
    adv          = '0;
    chain_adv    = v[DEPTH-1] & out_ready & ~hold;
    adv[DEPTH-1] = chain_adv;
    for (int i = DEPTH-2; i >= 0; i--) begin
      chain_adv = v[i] & (~v[i+1] | chain_adv) & ~hold;
      adv[i]    = chain_adv;
    end
  end

  assign in_ready  = ~hold & (~v[0] | adv[0]);
  assign take      = in_valid & in_ready;
  assign out_valid = v[DEPTH-1] & ~hold;
  assign out       = d[DEPTH-1];

  always_comb begin
    v_nxt    = v;
    v_nxt[0] = take | (v[0] & ~adv[0]);
    for (int i = 1; i < DEPTH; i++) begin
      v_nxt[i] = adv[i-1] | (v[i] & ~adv[i]);
    end
    if (hold) begin
      v_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      count <= '0;
    end else begin
      v     <= v_nxt;
      count <= popcount(v_nxt);
    end
  end

  // Data only moves with its valid bit; flush leaves it in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else begin
      if (take) begin
        d[0] <= in;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) begin
          d[i] <= d[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_nreg.sv
// tb/tb_pipe_nreg.sv - randomized and directed bench for pipe_nreg
// Two instances (DEPTH=3 and DEPTH=4) share stimulus; each has its own model.
module tb_pipe_nreg;
  localparam int NI = 16;
`ifdef PIPE_NREG_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] din = 8'h00;

  logic       in_ready3, out_valid3, in_ready4, out_valid4;
  logic [7:0] out3, out4;
  logic [1:0] count3;
  logic [2:0] count4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_nreg #(.WIDTH(8), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in(din),
    .out_valid(out_valid3), .out_ready(out_ready), .out(out3), .flush(flush), .count(count3)
  );

  pipe_nreg #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in(din),
    .out_valid(out_valid4), .out_ready(out_ready), .out(out4), .flush(flush), .count(count4)
  );

  // Model: ordered list of items (oldest first), each with its stage position.
  int         depth_of [2] = '{3, 4};
  int         mpos [2][NI];
  logic [7:0] mdat [2][NI];
  bit         mmove [2][NI];
  int         mn [2] = '{0, 0};
  logic [7:0] mlast [2] = '{8'h00, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic bit flush_now();
    return FLUSH_EN && flush;
  endfunction

  // An item moves one stage if there is a gap ahead or the item ahead moves.
  task automatic compute_moves(input int k);
    for (int j = 0; j < mn[k]; j++) begin
      if (flush_now())
        mmove[k][j] = 1'b0;
      else if (j == 0)
        mmove[k][j] = (mpos[k][0] == depth_of[k]-1) ? out_ready : 1'b1;
      else
        mmove[k][j] = (mpos[k][j] + 1 < mpos[k][j-1]) || mmove[k][j-1];
    end
  endtask

  function automatic bit model_in_ready(input int k);
    if (flush_now()) return 1'b0;
    if (mn[k] == 0) return 1'b1;
    if (mpos[k][mn[k]-1] != 0) return 1'b1;
    return mmove[k][mn[k]-1];
  endfunction

  task automatic model_step(input int k);
    int n;
    bit acc;
    compute_moves(k);
    acc = in_valid && model_in_ready(k);
    if (flush_now()) begin
      mn[k] = 0;
      return;
    end
    n = 0;
    for (int j = 0; j < mn[k]; j++) begin
      if (!(mmove[k][j] && mpos[k][j] == depth_of[k]-1)) begin
        mpos[k][n] = mpos[k][j] + (mmove[k][j] ? 1 : 0);
        mdat[k][n] = mdat[k][j];
        n++;
      end
    end
    if (acc) begin
      mpos[k][n] = 0;
      mdat[k][n] = din;
      n++;
    end
    mn[k] = n;
    if (n > 0 && mpos[k][0] == depth_of[k]-1) mlast[k] = mdat[k][0];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mn[k]    = 0;
        mlast[k] = 8'h00;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin : compare
    logic       ir, ov, ov_e;
    logic [7:0] o;
    int         c;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin
          ir = in_ready3; ov = out_valid3; o = out3; c = int'(count3);
        end else begin
          ir = in_ready4; ov = out_valid4; o = out4; c = int'(count4);
        end
        compute_moves(k);
        ov_e = !flush_now() && mn[k] > 0 && mpos[k][0] == depth_of[k]-1;
        check($sformatf("d%0d in_ready", depth_of[k]), 32'(ir), 32'(model_in_ready(k)));
        check($sformatf("d%0d out_valid", depth_of[k]), 32'(ov), 32'(ov_e));
        check($sformatf("d%0d out", depth_of[k]), 32'(o), 32'(mlast[k]));
        check($sformatf("d%0d count", depth_of[k]), 32'(c), 32'(mn[k]));
      end
    end
  end

  int         first_ov, peak, nout, acc, ready_pct;
  logic [7:0] got [8];
  int         gott [8];

  initial begin
    for (int j = 0; j < 8; j++) begin
      got[j] = 8'h00;
      gott[j] = -1;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset count3", 32'(count3), 0);
    check("reset out_valid3", 32'(out_valid3), 0);
    check("reset out3", 32'(out3), 0);
    check("reset in_ready3", 32'(in_ready3), 1);

    // Streaming 0x01..0x05 through DEPTH=3 with out_ready high
    out_ready = 1'b1;
    first_ov = -1; peak = 0; nout = 0;
    for (int t = 0; t < 14; t++) begin
      @(posedge clk); #1;
      in_valid = (t < 5);
      din = 8'(t + 1);
      @(negedge clk);
      if (out_valid3 && first_ov < 0) first_ov = t;
      if (out_valid3 && nout < 8) begin
        got[nout] = out3; gott[nout] = t; nout++;
      end
      if (int'(count3) > peak) peak = int'(count3);
    end
    check("stream latency", 32'(first_ov), 3);
    check("stream n_out", 32'(nout), 5);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("stream data%0d", j), 32'(got[j]), 32'(j + 1));
      check($sformatf("stream cycle%0d", j), 32'(gott[j]), 32'(3 + j));
    end
    check("stream peak count", 32'(peak), 3);

    // Asynchronous reset mid-cycle with data in flight
    @(posedge clk); #1;
    in_valid = 1'b1; din = 8'hA5; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async rst out_valid3", 32'(out_valid3), 0);
    check("async rst out3", 32'(out3), 0);
    check("async rst count3", 32'(count3), 0);
    check("async rst count4", 32'(count4), 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post rst count3", 32'(count3), 0);
    check("post rst in_ready3", 32'(in_ready3), 1);

    // Back-pressure: four items offered to a stalled DEPTH=3 chain
    acc = 0; out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      din = 8'h41 + 8'(acc);
      @(negedge clk);
      if (in_ready3) acc++;
    end
    check("bp accepted", 32'(acc), 3);
    check("bp in_ready3 full", 32'(in_ready3), 0);
    check("bp count3 full", 32'(count3), 3);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp in_ready3 drain", 32'(in_ready3), 1);
    check("bp out3 first", 32'(out3), 32'h41);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp count3 steady", 32'(count3), 3);
    check("bp out3 second", 32'(out3), 32'h42);
    repeat (10) @(posedge clk);

    // Bubble collapse on DEPTH=4
    #1 out_ready = 1'b0;
    in_valid = 1'b1; din = 8'h11;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 in_valid = 1'b1; din = 8'h22;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bubble count4", 32'(count4), 2);
    check("bubble out4 held", 32'(out4), 32'h11);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bubble first", 32'(out4), 32'h11);
    @(posedge clk); #1;
    @(negedge clk);
    check("bubble second valid", 32'(out_valid4), 1);
    check("bubble second", 32'(out4), 32'h22);
    repeat (10) @(posedge clk);

    // Flush with two items held and a simultaneous enqueue of 0x33
    #1 out_ready = 1'b0;
    in_valid = 1'b1; din = 8'h51;
    @(posedge clk); #1 din = 8'h52;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("flush pre count3", 32'(count3), 2);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; din = 8'h33;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
`ifdef PIPE_NREG_FLUSH_EN
    check("flush count3", 32'(count3), 0);
    check("flush out_valid3", 32'(out_valid3), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("flush no 0x33", 32'(out_valid3), 0);
      @(posedge clk); #1;
    end
`else
    check("noflush count3", 32'(count3), 3);
    @(posedge clk); #1 out_ready = 1'b1;
    nout = 0;
    for (int t = 0; t < 10 && nout < 3; t++) begin
      @(negedge clk);
      if (out_valid3) begin
        got[nout] = out3; nout++;
      end
      @(posedge clk); #1;
    end
    check("noflush n_out", 32'(nout), 3);
    check("noflush out0", 32'(got[0]), 32'h51);
    check("noflush out1", 32'(got[1]), 32'h52);
    check("noflush out2", 32'(got[2]), 32'h33);
`endif

    // Randomized traffic, checked every cycle by the compare process
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      case ((t / 250) % 3)
        0: ready_pct = 90;
        1: ready_pct = 30;
        default: ready_pct = 60;
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      din       = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      flush     = ($urandom_range(0, 39) == 0);
      if (t == 1500) begin
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
